// File: rtl/sprite_pkg.sv
// Shared types and sizing for the sprite line engine: table entry layout,
// per-line slot layout and scan state encoding.
package sprite_pkg;

  localparam int SPR_COUNT = 32;  // sprite attribute table entries
  localparam int SPR_SIZE  = 16;  // sprite width and height in pixels
  localparam int SLOTS     = 4;   // sprites kept per line

  localparam int IDX_W  = $clog2(SPR_COUNT);
  localparam int OFF_W  = $clog2(SPR_SIZE);
  localparam int SLOT_W = $clog2(SLOTS);

  // One sprite attribute table entry.
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       vis;
    logic [4:0] pattern;
  } entry_t;

  // One per-line slot: a sprite selected for a line, with its row offset.
  typedef struct packed {
    logic             valid;
    logic [9:0]       x;
    logic [4:0]       pattern;
    logic [OFF_W-1:0] row;
  } slot_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/sprite_line_engine_if.sv
// Sprite command bus from the execute stage: position and attribute writes
// into the sprite attribute table.
interface sprite_line_engine_if;

  logic [9:0] sprite_x;     // x position, or pattern id in [4:0] on attr write
  logic [8:0] sprite_y;     // y position
  logic [4:0] sprite_sel;   // table entry index
  logic       sprite_pos;   // pulse: write x, y, vis
  logic       sprite_attr;  // pulse: write pattern
  logic       sprite_vis;   // visible flag for position writes

  modport master (
    output sprite_x, sprite_y, sprite_sel, sprite_pos, sprite_attr, sprite_vis
  );

  modport slave (
    input sprite_x, sprite_y, sprite_sel, sprite_pos, sprite_attr, sprite_vis
  );

endinterface

// File: rtl/sprite_table.sv
// 32-entry sprite attribute table. Position and attribute writes land one
// cycle after the pulse; the scan port reads the current contents directly.
module sprite_table
  import sprite_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  sprite_line_engine_if.slave    cmd,
  input  logic [IDX_W-1:0]       rd_idx,
  output entry_t                 rd_entry
);

  entry_t tbl_q [SPR_COUNT];
  entry_t tbl_d [SPR_COUNT];

  // Next table contents: position and attribute groups are independent, so
  // simultaneous pulses update both field groups of the selected entry.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned, which would infer a latch.
    tbl_d = tbl_q;
    if (cmd.sprite_pos) begin
      tbl_d[cmd.sprite_sel].x   = cmd.sprite_x;
      tbl_d[cmd.sprite_sel].y   = cmd.sprite_y;
      tbl_d[cmd.sprite_sel].vis = cmd.sprite_vis;
    end
    if (cmd.sprite_attr) begin
      tbl_d[cmd.sprite_sel].pattern = cmd.sprite_x[4:0];
    end
  end

  // Table storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this array is reset explicitly because a freshly reset engine
      // must see every sprite invisible at position 0 with pattern 0; a plain
      // RAM without reset would leave garbage sprites on screen.
      for (int i = 0; i < SPR_COUNT; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      tbl_q <= tbl_d;
    end
  end

  assign rd_entry = tbl_q[rd_idx];

endmodule

// File: rtl/sprite_line_engine.sv
// Per-scanline sprite evaluator. Scans the attribute table once per line for
// sprites covering the latched line, keeps up to SLOTS of them, and at the
// next line_start swaps them into the active set used for per-pixel lookup.
module sprite_line_engine
  import sprite_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  sprite_line_engine_if.slave  cmd,
  input  logic                 line_start,
  input  logic [8:0]           scan_line,
  input  logic [9:0]           pixel_x,
  output logic                 spr_hit,
  output logic [4:0]           spr_pattern,
  output logic [OFF_W-1:0]     spr_row,
  output logic [OFF_W-1:0]     spr_col,
  output logic                 spr_overflow,
  output logic                 scan_busy
);

  // Scan control state.
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [8:0]         line_q, line_d;
  logic               acc_q, acc_d;
  logic               ovf_q, ovf_d;

  // Slot sets: eval is being built for the next line, active is displayed.
  slot_t              eval_q [SLOTS];
  slot_t              eval_d [SLOTS];
  slot_t              active_q [SLOTS];
  slot_t              active_d [SLOTS];

  // Registered pixel lookup result.
  logic               hit_q, hit_d;
  logic [4:0]         pat_q, pat_d;
  logic [OFF_W-1:0]   row_q, row_d;
  logic [OFF_W-1:0]   col_q, col_d;

  // Scan datapath.
  entry_t             scan_entry;
  logic [9:0]         line_diff;
  logic               match;
  logic               free_found;
  logic [SLOT_W-1:0]  free_slot;
  logic               no_room;

  sprite_table u_table (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cmd),
    .rd_idx   (idx_q),
    .rd_entry (scan_entry)
  );

  // Scan sequencing, slot filling, overflow accumulation and set swap.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    line_d   = line_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    eval_d   = eval_q;
    active_d = active_q;

    // Lowest free eval slot keeps table order, so slot 0 is frontmost.
    free_found = 1'b0;
    free_slot  = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (!free_found && !eval_q[s].valid) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(s);
      end
    end

    // Zero-extended subtract: a sprite above line 0 never wraps to the bottom.
    line_diff = {1'b0, line_q} - {1'b0, scan_entry.y};
    match     = (state_q == SCAN) && scan_entry.vis
                && (line_diff < 10'(SPR_SIZE));
    no_room   = match && !free_found;

    if (line_start) begin
      // Start (or restart) a scan; the set built so far becomes visible.
      active_d = eval_q;
      for (int s = 0; s < SLOTS; s++) begin
        eval_d[s] = '0;
      end
      line_d  = scan_line;
      idx_d   = '0;
      acc_d   = 1'b0;
      state_d = SCAN;
    end else if (state_q == SCAN) begin
      if (match && free_found) begin
        eval_d[free_slot].valid   = 1'b1;
        eval_d[free_slot].x       = scan_entry.x;
        eval_d[free_slot].pattern = scan_entry.pattern;
        eval_d[free_slot].row     = line_diff[OFF_W-1:0];
      end
      acc_d = acc_q | no_room;
      if (idx_q == IDX_W'(SPR_COUNT - 1)) begin
        // Only a completed scan publishes its overflow status.
        ovf_d   = acc_q | no_room;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Pixel lookup against the active set; lowest matching slot wins.
  always_comb begin
    logic [10:0] pix_diff;
    hit_d    = 1'b0;
    pat_d    = '0;
    row_d    = '0;
    col_d    = '0;
    pix_diff = '0;
    for (int s = 0; s < SLOTS; s++) begin
      pix_diff = {1'b0, pixel_x} - {1'b0, active_q[s].x};
      if (!hit_d && active_q[s].valid && (pix_diff < 11'(SPR_SIZE))) begin
        hit_d = 1'b1;
        pat_d = active_q[s].pattern;
        row_d = active_q[s].row;
        col_d = pix_diff[OFF_W-1:0];
      end
    end
  end

  // FSM, slot sets and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      line_q  <= '0;
      acc_q   <= 1'b0;
      ovf_q   <= 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        eval_q[s]   <= '0;
        active_q[s] <= '0;
      end
      hit_q   <= 1'b0;
      pat_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      line_q   <= line_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      eval_q   <= eval_d;
      active_q <= active_d;
      hit_q    <= hit_d;
      pat_q    <= pat_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign spr_hit      = hit_q;
  assign spr_pattern  = pat_q;
  assign spr_row      = row_q;
  assign spr_col      = col_q;
  assign spr_overflow = ovf_q;
  assign scan_busy    = (state_q == SCAN);

endmodule

// File: tb/tb_sprite_line_engine.sv
// Self-checking bench for sprite_line_engine. A behavioural model keeps the
// sprite table as plain arrays and derives each line's sprite list and the
// per-pixel result directly from the coverage rules.
module tb_sprite_line_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       line_start;
  logic [8:0] scan_line;
  logic [9:0] pixel_x;
  logic       spr_hit;
  logic [4:0] spr_pattern;
  logic [3:0] spr_row;
  logic [3:0] spr_col;
  logic       spr_overflow;
  logic       scan_busy;

  sprite_line_engine_if cmd_if ();

  sprite_line_engine dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd_if),
    .line_start   (line_start),
    .scan_line    (scan_line),
    .pixel_x      (pixel_x),
    .spr_hit      (spr_hit),
    .spr_pattern  (spr_pattern),
    .spr_row      (spr_row),
    .spr_col      (spr_col),
    .spr_overflow (spr_overflow),
    .scan_busy    (scan_busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int x;
    int pat;
    int row;
  } mslot_t;

  int     m_x [32];
  int     m_y [32];
  int     m_pat [32];
  bit     m_vis [32];
  mslot_t m_act [$];
  mslot_t m_ev [$];
  bit     m_ev_ovf;
  bit     m_ovf;

  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_pat[i] = 0; m_vis[i] = 1'b0;
    end
    m_act.delete();
    m_ev.delete();
    m_ev_ovf = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // Sprites covering a line, in table order, capped at four.
  task automatic model_scan(input int line);
    mslot_t s;
    m_ev.delete();
    m_ev_ovf = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (m_vis[i] && line >= m_y[i] && line - m_y[i] < 16) begin
        if (m_ev.size() < 4) begin
          s.x = m_x[i]; s.pat = m_pat[i]; s.row = line - m_y[i];
          m_ev.push_back(s);
        end else begin
          m_ev_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic model_pixel(input int px, output bit hit, output int pat,
                             output int row, output int col);
    hit = 1'b0; pat = 0; row = 0; col = 0;
    foreach (m_act[k]) begin
      if (!hit && px >= m_act[k].x && px - m_act[k].x < 16) begin
        hit = 1'b1; pat = m_act[k].pat; row = m_act[k].row; col = px - m_act[k].x;
      end
    end
  endtask

  // ---------------- drivers (all start and end on a falling edge) ----------------
  task automatic do_reset();
    reset = 1'b1;
    line_start = 1'b0; scan_line = '0; pixel_x = '0;
    cmd_if.sprite_x = '0; cmd_if.sprite_y = '0; cmd_if.sprite_sel = '0;
    cmd_if.sprite_pos = 1'b0; cmd_if.sprite_attr = 1'b0; cmd_if.sprite_vis = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic write_pos(input int sel, input int x, input int y, input bit vis);
    cmd_if.sprite_sel = 5'(sel); cmd_if.sprite_x = 10'(x);
    cmd_if.sprite_y = 9'(y); cmd_if.sprite_vis = vis; cmd_if.sprite_pos = 1'b1;
    @(negedge clk);
    cmd_if.sprite_pos = 1'b0;
    m_x[sel] = x; m_y[sel] = y; m_vis[sel] = vis;
  endtask

  task automatic write_attr(input int sel, input int pat);
    cmd_if.sprite_sel = 5'(sel); cmd_if.sprite_x = 10'(pat); cmd_if.sprite_attr = 1'b1;
    @(negedge clk);
    cmd_if.sprite_attr = 1'b0;
    m_pat[sel] = pat % 32;
  endtask

  task automatic write_both(input int sel, input int x, input int y, input bit vis);
    cmd_if.sprite_sel = 5'(sel); cmd_if.sprite_x = 10'(x); cmd_if.sprite_y = 9'(y);
    cmd_if.sprite_vis = vis; cmd_if.sprite_pos = 1'b1; cmd_if.sprite_attr = 1'b1;
    @(negedge clk);
    cmd_if.sprite_pos = 1'b0; cmd_if.sprite_attr = 1'b0;
    m_x[sel] = x; m_y[sel] = y; m_vis[sel] = vis; m_pat[sel] = x % 32;
  endtask

  task automatic pulse_line(input int line);
    scan_line = 9'(line); line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Full line: swap, scan to completion, publish overflow.
  task automatic do_line(input int line);
    m_act = m_ev;
    model_scan(line);
    pulse_line(line);
    repeat (32) @(negedge clk);
    m_ovf = m_ev_ovf;
  endtask

  task automatic sample_pixel(input int px, output bit eh, output int ep,
                              output int er, output int ec);
    pixel_x = 10'(px);
    @(negedge clk);
    model_pixel(px, eh, ep, er, ec);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (spr_hit !== 1'b0) begin
      errors++; $display("FAIL reset_hit: got %0b expected 0", spr_hit);
    end
    checks++;
    if ({spr_pattern, spr_row, spr_col} !== 13'd0) begin
      errors++; $display("FAIL reset_fields: got pat=%0d row=%0d col=%0d expected 0",
                         spr_pattern, spr_row, spr_col);
    end
    checks++;
    if ({spr_overflow, scan_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got ovf=%0b busy=%0b expected 0 0",
                         spr_overflow, scan_busy);
    end
  endtask

  task automatic test_empty_line();
    bit eh; int ep, er, ec;
    m_act = m_ev;
    model_scan(10);
    pulse_line(10);
    checks++;
    if (scan_busy !== 1'b1) begin
      errors++; $display("FAIL empty_busy_start: got %0b expected 1", scan_busy);
    end
    repeat (32) @(negedge clk);
    m_ovf = m_ev_ovf;
    checks++;
    if (scan_busy !== 1'b0 || spr_overflow !== m_ovf) begin
      errors++; $display("FAIL empty_scan_end: got busy=%0b ovf=%0b expected busy=0 ovf=%0b",
                         scan_busy, spr_overflow, m_ovf);
    end
    for (int k = 0; k < 4; k++) begin
      sample_pixel($urandom_range(0, 1023), eh, ep, er, ec);
      checks++;
      if (spr_hit !== eh) begin
        errors++; $display("FAIL empty_pixel: px=%0d got hit=%0b expected %0b", pixel_x, spr_hit, eh);
      end
    end
  endtask

  // Shared pixel list comparison used by directed scenarios.
  task automatic test_pixels(input string name, input int pxs [$]);
    bit eh; int ep, er, ec;
    foreach (pxs[k]) begin
      sample_pixel(pxs[k], eh, ep, er, ec);
      checks++;
      if (spr_hit !== eh || (eh && (spr_pattern !== 5'(ep) || spr_row !== 4'(er)
                                    || spr_col !== 4'(ec)))) begin
        errors++;
        $display("FAIL %s px=%0d: got hit=%0b pat=%0d row=%0d col=%0d, expected hit=%0b pat=%0d row=%0d col=%0d",
                 name, pxs[k], spr_hit, spr_pattern, spr_row, spr_col, eh, ep, er, ec);
      end
    end
  endtask

  task automatic test_single_sprite();
    do_reset();
    write_pos(3, 100, 5, 1'b1);
    write_attr(3, 7);
    do_line(12);
    do_line(12);
    // 104 -> pattern 7, row 7, col 4; 116 is past the right edge.
    test_pixels("single", '{104, 100, 115, 116, 99});
  endtask

  task automatic test_priority();
    do_reset();
    write_pos(9, 50, 20, 1'b1);  write_attr(9, 22);
    write_pos(2, 45, 15, 1'b1);  write_attr(2, 11);
    do_line(20);
    do_line(20);
    test_pixels("priority", '{50, 60, 61, 65, 66});
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      write_pos(i, 40 * i + 10, 25, 1'b1);
      write_attr(i, i + 1);
    end
    do_line(30);
    checks++;
    if (spr_overflow !== m_ovf || m_ovf !== 1'b1) begin
      errors++; $display("FAIL overflow_flag: got %0b expected 1", spr_overflow);
    end
    do_line(30);
    test_pixels("overflow", '{10, 50, 90, 130, 170, 210});
  endtask

  task automatic test_no_wrap();
    do_reset();
    write_pos(1, 600, 470, 1'b1); write_attr(1, 4);
    write_pos(2, 300, 0, 1'b1);   write_attr(2, 9);
    do_line(5);
    do_line(15);
    test_pixels("wrap_line5", '{600, 605, 300});
    do_line(16);
    test_pixels("edge_line15", '{300, 315});
    do_line(0);
    test_pixels("edge_line16", '{300, 600});
    checks++;
    if (spr_overflow !== m_ovf) begin
      errors++; $display("FAIL wrap_ovf: got %0b expected %0b", spr_overflow, m_ovf);
    end
  endtask

  task automatic test_mid_scan_write();
    do_reset();
    write_pos(0, 200, 35, 1'b1);
    write_attr(0, 3);
    m_act = m_ev;
    model_scan(40);
    pulse_line(40);
    repeat (10) @(negedge clk);       // index 10 is being scanned now
    write_pos(0, 200, 300, 1'b1);     // entry 0 already scanned this line
    repeat (21) @(negedge clk);
    m_ovf = m_ev_ovf;
    do_line(40);
    test_pixels("midwrite_old", '{200, 205});
    do_line(40);
    test_pixels("midwrite_new", '{200});
  endtask

  task automatic test_restart();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      write_pos(i, 40 * i + 10, 25, 1'b1);
      write_attr(i, i + 1);
    end
    do_line(30);
    // New patterns so the restarted partial set is distinguishable.
    for (int i = 0; i < 6; i++) begin
      write_attr(i, 20 + i);
    end
    m_act = m_ev;
    model_scan(30);
    pulse_line(30);
    repeat (12) @(negedge clk);       // index 12 is being scanned now
    m_act = m_ev;                     // indices 0..11 already hold all matches
    model_scan(200);
    pulse_line(200);
    checks++;
    if (spr_overflow !== m_ovf || scan_busy !== 1'b1) begin
      errors++; $display("FAIL restart_hold: got ovf=%0b busy=%0b expected ovf=%0b busy=1",
                         spr_overflow, scan_busy, m_ovf);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (scan_busy !== 1'b1) begin
      errors++; $display("FAIL restart_len: got busy=%0b expected 1", scan_busy);
    end
    repeat (2) @(negedge clk);
    m_ovf = m_ev_ovf;
    checks++;
    if (scan_busy !== 1'b0 || spr_overflow !== m_ovf) begin
      errors++; $display("FAIL restart_end: got busy=%0b ovf=%0b expected busy=0 ovf=%0b",
                         scan_busy, spr_overflow, m_ovf);
    end
    test_pixels("restart", '{10, 50, 90, 130, 170, 210});
  endtask

  task automatic test_random();
    bit eh; int ep, er, ec;
    int line, y, x, px, mode, j;
    do_reset();
    for (int it = 0; it < 5; it++) begin
      line = $urandom_range(0, 511);
      for (int i = 0; i < 32; i++) begin
        x = $urandom_range(0, 1023);
        if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 511);
        else y = (line - int'($urandom_range(0, 20))) & 511;
        mode = $urandom_range(0, 2);
        if (mode == 0) begin
          write_pos(i, x, y, $urandom_range(0, 2) == 0);
          write_attr(i, $urandom_range(0, 31));
        end else if (mode == 1) begin
          write_both(i, x, y, $urandom_range(0, 2) == 0);
        end else begin
          write_pos(i, x, y, $urandom_range(0, 2) == 0);
        end
      end
      do_line(line);
      checks++;
      if (spr_overflow !== m_ovf) begin
        errors++; $display("FAIL rand_ovf it=%0d: got %0b expected %0b", it, spr_overflow, m_ovf);
      end
      for (int k = 0; k < 12; k++) begin
        if (m_act.size() > 0 && k < 9) begin
          j  = $urandom_range(0, m_act.size() - 1);
          px = m_act[j].x + int'($urandom_range(0, 17)) - 1;
          if (px < 0) px = 0;
          if (px > 1023) px = 1023;
        end else begin
          px = $urandom_range(0, 1023);
        end
        sample_pixel(px, eh, ep, er, ec);
        checks++;
        if (spr_hit !== eh || (eh && (spr_pattern !== 5'(ep) || spr_row !== 4'(er)
                                      || spr_col !== 4'(ec)))) begin
          errors++;
          $display("FAIL rand_pixel it=%0d px=%0d: got hit=%0b pat=%0d row=%0d col=%0d, expected hit=%0b pat=%0d row=%0d col=%0d",
                   it, px, spr_hit, spr_pattern, spr_row, spr_col, eh, ep, er, ec);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_empty_line();
    test_single_sprite();
    test_priority();
    test_overflow();
    test_no_wrap();
    test_mid_scan_write();
    test_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
